// File: rtl/master_mem_control.sv
// Tile address generator: drives 16 skewed lane addresses row by row over a
// rows x cols tile, then pulses done for one cycle before returning to idle.
module master_mem_control (
  input  logic         clk,
  input  logic         reset,
  input  logic         active,
  input  logic [7:0]   base_addr,
  input  logic [4:0]   num_row,
  input  logic [4:0]   num_col,
  output logic [127:0] out_addr,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [4:0]   r_step, w_step_nxt;
  logic [7:0]   r_base, w_base_nxt;
  logic [4:0]   r_rows, w_rows_nxt;
  logic [4:0]   r_cols, w_cols_nxt;
  logic [4:0]   w_row_clamp, w_col_clamp;
  logic [5:0]   w_last;
  logic [127:0] w_addr_nxt;

  assign w_row_clamp = (num_row > 5'd16) ? 5'd16 : num_row;
  assign w_col_clamp = (num_col > 5'd16) ? 5'd16 : num_col;
  assign w_last      = {1'b0, r_rows} + {1'b0, r_cols} - 6'd2;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_base_nxt  = r_base;
    w_rows_nxt  = r_rows;
    w_cols_nxt  = r_cols;
    case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE) w_state_nxt = IDLE;
        if (active) begin
          w_base_nxt  = base_addr;
          w_rows_nxt  = w_row_clamp;
          w_cols_nxt  = w_col_clamp;
          w_step_nxt  = 5'd0;
          w_state_nxt = (w_row_clamp == 5'd0 || w_col_clamp == 5'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ({1'b0, r_step} == w_last) begin
          w_state_nxt = DONE;
          w_step_nxt  = 5'd0;
        end else begin
          w_step_nxt = r_step + 5'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the post-edge state so they register in step.
  always_comb begin
    w_addr_nxt = '0;
    if (w_state_nxt == RUN) begin
      for (int i = 0; i < 16; i++) begin
        if (5'(i) < w_cols_nxt && w_step_nxt >= 5'(i) &&
            (w_step_nxt - 5'(i)) < w_rows_nxt)
          w_addr_nxt[8*i +: 8] = w_base_nxt + {3'b000, w_step_nxt - 5'(i)};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_base   <= '0;
      r_rows   <= '0;
      r_cols   <= '0;
      out_addr <= '0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_base   <= w_base_nxt;
      r_rows   <= w_rows_nxt;
      r_cols   <= w_cols_nxt;
      out_addr <= w_addr_nxt;
      done     <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_master_mem_control.sv
// Directed bench for master_mem_control with hand-computed lane addresses.
module tb_master_mem_control;

  logic         clk;
  logic         reset;
  logic         active;
  logic [7:0]   base_addr;
  logic [4:0]   num_row;
  logic [4:0]   num_col;
  logic [127:0] out_addr;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  master_mem_control dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .base_addr (base_addr),
    .num_row   (num_row),
    .num_col   (num_col),
    .out_addr  (out_addr),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of cycle 1 (step 0 visible).
  task automatic start(input logic [7:0] b, input logic [4:0] r, input logic [4:0] c);
    @(negedge clk);
    base_addr = b;
    num_row   = r;
    num_col   = c;
    active    = 1'b1;
    @(negedge clk);
    active    = 1'b0;
  endtask

  // Starts a run, probes out_addr at one cycle, and checks the done cycle.
  task automatic run_probe(input string tag, input logic [7:0] b, input logic [4:0] r,
                           input logic [4:0] c, input int probe_c,
                           input logic [127:0] probe_exp, input int exp_len);
    int cyc;
    start(b, r, c);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == probe_c) check({tag, "_probe"}, out_addr, probe_exp);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, 128'(cyc), 128'(exp_len));
    check({tag, "_done_out"}, out_addr, '0);
    @(negedge clk);
  endtask

  initial begin
    int  cyc;
    logic bad;
    reset = 1'b1; active = 1'b0; base_addr = '0; num_row = '0; num_col = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out_addr, '0);
    check("reset_done", 128'(done), 128'(0));
    reset = 1'b0;

    // Basic 2x2
    start(8'h10, 5'd2, 5'd2);
    check("b22_c1", out_addr, 128'h10);
    @(negedge clk); check("b22_c2", out_addr, 128'h1011);
    @(negedge clk); check("b22_c3", out_addr, 128'h1100);
    check("b22_c3_done", 128'(done), 128'(0));
    @(negedge clk); check("b22_c4_done", 128'(done), 128'(1));
    check("b22_c4_out", out_addr, '0);
    @(negedge clk); check("b22_c5_done", 128'(done), 128'(0));

    // Full 15x15
    start(8'h00, 5'd15, 5'd15);
    bad = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      if (out_addr[127:120] !== 8'h00 || done !== 1'b0) bad = 1'b1;
      if (c == 15) begin
        check("f15_s14_lane0", 128'(out_addr[7:0]), 128'h0E);
        check("f15_s14_lane1", 128'(out_addr[15:8]), 128'h0D);
        check("f15_s14_lane13", 128'(out_addr[111:104]), 128'h01);
        check("f15_s14_lane14", 128'(out_addr[119:112]), 128'h00);
      end
      if (c == 29) check("f15_s28", out_addr, 128'h0E << 112);
      @(negedge clk);
    end
    check("f15_lane15_and_done_quiet", 128'(bad), 128'(0));
    check("f15_c30_done", 128'(done), 128'(1));
    @(negedge clk);

    // Wrap
    start(8'hFE, 5'd3, 5'd1);
    check("wrap_c1", out_addr, 128'hFE);
    @(negedge clk); check("wrap_c2", out_addr, 128'hFF);
    @(negedge clk); check("wrap_c3", out_addr, 128'h00);
    check("wrap_c3_done", 128'(done), 128'(0));
    @(negedge clk); check("wrap_c4_done", 128'(done), 128'(1));
    @(negedge clk);

    // Zero size
    start(8'h20, 5'd0, 5'd5);
    check("zero_c1_done", 128'(done), 128'(1));
    check("zero_c1_out", out_addr, '0);
    @(negedge clk);
    check("zero_c2_done", 128'(done), 128'(0));
    check("zero_c2_out", out_addr, '0);

    // Clamps: 16 rows x 1 col and 1 row x 16 cols both last 16 cycles
    run_probe("clamp_rows", 8'h40, 5'd31, 5'd1, 16, 128'h4F, 17);
    run_probe("clamp_cols", 8'h80, 5'd1, 5'd31, 16, 128'h80 << 120, 17);

    // Reset at step 3 of a 4x4 run
    start(8'h30, 5'd4, 5'd4);
    repeat (3) @(negedge clk);
    check("rst_s3", out_addr, 128'h30313233);
    #1 reset = 1'b1;
    #1;
    check("rst_async_out", out_addr, '0);
    check("rst_async_done", 128'(done), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || out_addr !== '0) bad = 1'b1;
    end
    check("rst_stays_idle", 128'(bad), 128'(0));

    // active re-pulsed during RUN is ignored
    start(8'h50, 5'd2, 5'd2);
    base_addr = 8'hA0; num_row = 5'd9; num_col = 5'd9; active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    check("ign_c2", out_addr, 128'h5051);
    cyc = 2;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_done_cycle", 128'(cyc), 128'(4));

    // New start accepted on the edge leaving DONE
    base_addr = 8'h60; num_row = 5'd1; num_col = 5'd1; active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    check("b2b_c1", out_addr, 128'h60);
    check("b2b_c1_done", 128'(done), 128'(0));
    @(negedge clk);
    check("b2b_c2_done", 128'(done), 128'(1));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/master_mem_control.md
MASTER_MEM_CONTROL -- requirements
Module: master_mem_control

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 SHALL expose these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- active  input  1  start strobe, sampled on the rising edge of clk
- base_addr  input  8  start address of the tile
- num_row  input  5  rows in the tile, 0..16
- num_col  input  5  columns (lanes) in the tile, 0..16
- out_addr  output  128  16 lane addresses; lane i is out_addr[8i+7:8i]
- done  output  1  one-cycle completion pulse
REQ-003 SHALL have no parameters; lane count is fixed at 16 and address width at 8 bits.

Function
REQ-004 SHALL implement states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-005 In IDLE, active=1 at a clock edge SHALL:
- latch base_addr, num_row and num_col;
- set step=0;
- move to RUN.
REQ-006 If latched num_row=0 or num_col=0, the start SHALL go directly to DONE instead of RUN.
REQ-007 Latched num_row and num_col values above 16 SHALL be clamped to 16.
REQ-008 active SHALL be ignored in RUN and DONE; input changes after the start SHALL not affect a running sequence.
REQ-009 In RUN, each lane uses a skewed row index r = step - i, giving a systolic stagger of one cycle per lane.
REQ-010 Lane i SHALL output base_addr + r (modulo 256) when i < num_col and 0 <= r < num_row; otherwise it SHALL output 8'h00.
REQ-011 The outputs for step s SHALL be visible in the cycle after the edge that set step=s; step 0 is visible in the cycle after the accepting edge.
REQ-012 step SHALL increment by 1 per clock in RUN, from 0 to last = num_row + num_col - 2.
REQ-013 After step=last, the next edge SHALL enter DONE with out_addr=0 and done=1 for exactly one cycle; the following edge SHALL return to IDLE with done=0.
REQ-014 A new active may be accepted on the edge that leaves DONE; it starts a new sequence exactly as in IDLE.
REQ-015 Address arithmetic SHALL wrap modulo 256 (e.g. base 0xFF, r=1 -> 0x00).
REQ-016 Outside RUN, out_addr SHALL be all zeros.

Reset
REQ-017 reset=1 SHALL immediately and asynchronously force:
- state IDLE;
- step 0;
- out_addr 0;
- done 0;
- latched registers 0.
REQ-018 Reset asserted mid-sequence SHALL abort it with no done pulse.
REQ-019 After reset deasserts, the block SHALL wait for a new active.

Verification
REQ-020 Basic 2x2: base=0x10, rows=2, cols=2, active pulsed for 1 cycle -> three RUN cycles, then done.
- Cycle 1: lane0=0x10, others 0.
- Cycle 2: lane0=0x11, lane1=0x10.
- Cycle 3: lane0=0, lane1=0x11.
- Cycle 4: done=1, out_addr=0.
REQ-021 Full 15x15: base=0x00, rows=15, cols=15 -> 29 RUN cycles.
- At step 14: lane0=0x0E and lane14=0x00; lane15 stays 0 throughout.
- done=1 in cycle 30.
REQ-022 Wrap: base=0xFE, rows=3, cols=1 -> lane0 outputs 0xFE, 0xFF, 0x00, then done.
REQ-023 Zero size and clamp:
- rows=0, cols=5 -> done=1 in the cycle after the start, out_addr=0 throughout.
- rows=31 -> behaves as rows=16.
REQ-024 Reset and ignore:
- Assert reset at step 3 of a 4x4 run -> out_addr=0 immediately, no done, IDLE.
- active re-pulsed during RUN -> ignored; sequence length unchanged.
